chnl_tx_arbiter: RTL
====================

# chnl_tx_arbiter

Round-robin scheduler that shares one RIFFA TX channel among C_NUM_REQ user-side stream requesters. Each requester asks for the channel with a word length. The block grants one requester at a time and opens the RIFFA transaction. It then muxes that requester's data onto CHNL_TX_* and counts words, closing the transaction after exactly the requested length. It sits between the user cores and the RIFFA channel port, in the same clock domain as the channel.

## Interface
- C_PCI_DATA_WIDTH, 32, data width in bits; legal values 32/64/128.
- C_NUM_REQ, 4, number of requesters, 2..8.
- C_REQ_IDX_W, 2, width of the requester index, $clog2(C_NUM_REQ).

- CLK  in  1  single clock for all logic; CHNL_TX_CLK = CLK.
- RST_N  in  1  asynchronous, active-low reset.
- REQ  in  C_NUM_REQ  per-requester channel request, level.
- REQ_LEN  in  32*C_NUM_REQ  per-requester transfer length in 32-bit words.
- REQ_LAST  in  C_NUM_REQ  per-requester LAST flag, forwarded to CHNL_TX_LAST.
- REQ_DATA  in  C_PCI_DATA_WIDTH*C_NUM_REQ  per-requester data.
- REQ_DATA_VALID  in  C_NUM_REQ  per-requester data valid.
- REQ_DATA_REN  out  C_NUM_REQ  data read-enable to the granted requester only.
- GNT  out  C_NUM_REQ  one-hot grant, held for the whole transaction.
- REQ_DONE  out  C_NUM_REQ  one-cycle pulse on the granted bit when its transfer completes.
- CHNL_TX_CLK  out  1  equals CLK.
- CHNL_TX  out  1  transaction open.
- CHNL_TX_ACK  in  1  RIFFA acceptance of the transaction.
- CHNL_TX_LAST  out  1  latched REQ_LAST of the granted requester.
- CHNL_TX_LEN  out  32  latched REQ_LEN of the granted requester.
- CHNL_TX_OFF  out  31  constant 0.
- CHNL_TX_DATA  out  C_PCI_DATA_WIDTH  REQ_DATA of the granted requester.
- CHNL_TX_DATA_VALID  out  1  data valid toward RIFFA.
- CHNL_TX_DATA_REN  in  1  RIFFA read-enable.

## Operation
- Constant K = C_PCI_DATA_WIDTH/32, the words per beat.
- States:
  - IDLE: if REQ has any bit set, pick the first set bit at or after rr_ptr (wrapping), latch its index, REQ_LEN and REQ_LAST, and go to OPEN. Otherwise stay in IDLE.
  - OPEN: assert GNT[idx] and CHNL_TX. On CHNL_TX_ACK go to XFER, or to DONE when the latched length is 0.
  - XFER: CHNL_TX stays high. Let active = (wcnt < len).
    - CHNL_TX_DATA_VALID = active & REQ_DATA_VALID[idx].
    - REQ_DATA_REN[idx] = active & CHNL_TX_DATA_REN.
    - A beat is accepted when VALID and REN are both high; wcnt += K.
    - Go to DONE on the accepted beat where wcnt + K >= len.
  - DONE: CHNL_TX, GNT and REN are low. Pulse REQ_DONE[idx] for one cycle, set rr_ptr = idx+1 mod C_NUM_REQ, clear wcnt, and go to IDLE.
- wcnt is 32 bits and is compared unsigned. When len is not a multiple of K, the final beat is partially used and the beat count is ceil(len/K).
- REQ, REQ_LEN and REQ_LAST are sampled only in IDLE. Changing or dropping REQ after the grant has no effect, and the transfer runs to completion.
- Non-granted REQ_DATA_REN bits are always 0. CHNL_TX_DATA follows the granted requester combinationally.
- Reset (RST_N low, at any time including mid-transfer):
  - State goes to IDLE, and rr_ptr, wcnt and the latched idx/len/last are cleared.
  - All outputs go to 0: CHNL_TX, CHNL_TX_LAST, CHNL_TX_LEN, CHNL_TX_DATA_VALID, GNT, REQ_DATA_REN, REQ_DONE.
  - No REQ_DONE is issued for the aborted transfer.

## Timing
- Grant latency: REQ sampled high in IDLE at edge n gives GNT and CHNL_TX high from cycle n+1.
- The first beat can be accepted in the cycle after CHNL_TX_ACK is sampled.
- The final accepted beat is at edge m. DONE is in cycle m+1, with CHNL_TX low and REQ_DONE high. IDLE is in cycle m+2.
- Minimum gap between transactions: 2 cycles from the last beat to the next CHNL_TX rise.
- VALID/REN stalls of any length are tolerated, and wcnt advances only on accepted beats.
- A requester that holds REQ continuously is re-granted only after every other active requester has been served once.

## Structure
- Package chnl_arb_pkg holds:
  - the state enum (IDLE, OPEN, XFER, DONE);
  - the K (words-per-beat) function;
  - the 32-bit length type.
- Sub-module rr_arbiter: combinational rotating-priority pick. Inputs are the REQ vector and rr_ptr; outputs are a one-hot vector, an index and an any-valid flag.

## Test plan
- Single requester: width 32, REQ[0], LEN=4, constant VALID/REN → CHNL_TX_LEN=4, 4 beats, REQ_DONE[0] 1 cycle after beat 4, CHNL_TX low in that cycle.
- Round robin: REQ[0] and REQ[2] held, LEN=2 each, starting from reset → grant order 0, 2, 0, 2; no back-to-back grant to the same requester.
- Zero length: REQ[1], LEN=0 → CHNL_TX high until ACK, no VALID, REQ_DONE[1] the cycle after ACK.
- Width 64, LEN=3 → exactly 2 beats accepted, wcnt 0→2→4, then DONE.
- Backpressure: LEN=4 with REN toggled 1,0,0,1,… and VALID gaps → exactly 4 accepted beats and data order preserved.
- RST_N pulsed low mid-XFER, after 2 of 8 beats → all outputs 0 immediately, no REQ_DONE; a new request after reset is granted from rr_ptr=0.

Source files
------------

// File: rtl/chnl_arb_pkg.sv
// Shared types and helpers for the RIFFA TX channel arbiter.
package chnl_arb_pkg;

  // Transaction phases: pick a requester, open the channel, move data, retire.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPEN = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_e;

  // Transfer lengths and word counters are always counted in 32-bit words.
  typedef logic [31:0] len_t;

  // Number of 32-bit words carried by one data beat of the given bus width.
  function automatic int unsigned words_per_beat(input int unsigned data_width);
    return data_width / 32;
  endfunction

endpackage

// File: rtl/chnl_tx_arbiter_rr_arbiter.sv
// Rotating-priority picker: returns the first set request at or after rr_ptr,
// wrapping around the end of the request vector.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] pick_onehot,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               pick_valid
);

  // Scan from the farthest candidate back to rr_ptr so the nearest set request wins.
  always_comb begin
    logic [IDX_W-1:0] cand_idx;
    pick_onehot = '0;
    pick_idx    = '0;
    pick_valid  = 1'b0;
    cand_idx    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand_idx = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (req[cand_idx]) begin
        pick_valid            = 1'b1;
        pick_idx              = cand_idx;
        pick_onehot           = '0;
        pick_onehot[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/chnl_tx_arbiter.sv
// Round-robin scheduler sharing one RIFFA TX channel among several stream
// requesters. One requester is granted per transaction; its data is muxed onto
// CHNL_TX_* and words are counted until the latched length has been sent.
module chnl_tx_arbiter
  import chnl_arb_pkg::*;
#(
  parameter int C_PCI_DATA_WIDTH = 32,
  parameter int C_NUM_REQ        = 4,
  parameter int C_REQ_IDX_W      = 2
) (
  input  logic                                  CLK,
  input  logic                                  RST_N,
  input  logic [C_NUM_REQ-1:0]                  REQ,
  input  logic [32*C_NUM_REQ-1:0]               REQ_LEN,
  input  logic [C_NUM_REQ-1:0]                  REQ_LAST,
  input  logic [C_PCI_DATA_WIDTH*C_NUM_REQ-1:0] REQ_DATA,
  input  logic [C_NUM_REQ-1:0]                  REQ_DATA_VALID,
  output logic [C_NUM_REQ-1:0]                  REQ_DATA_REN,
  output logic [C_NUM_REQ-1:0]                  GNT,
  output logic [C_NUM_REQ-1:0]                  REQ_DONE,
  output logic                                  CHNL_TX_CLK,
  output logic                                  CHNL_TX,
  input  logic                                  CHNL_TX_ACK,
  output logic                                  CHNL_TX_LAST,
  output logic [31:0]                           CHNL_TX_LEN,
  output logic [30:0]                           CHNL_TX_OFF,
  output logic [C_PCI_DATA_WIDTH-1:0]           CHNL_TX_DATA,
  output logic                                  CHNL_TX_DATA_VALID,
  input  logic                                  CHNL_TX_DATA_REN
);

  localparam int unsigned K     = words_per_beat(C_PCI_DATA_WIDTH);
  localparam logic [32:0] K_EXT = 33'(K);

  state_e                 state_q, state_d;
  logic [C_REQ_IDX_W-1:0] idx_q, idx_d;
  logic [C_NUM_REQ-1:0]   gnt_oh_q, gnt_oh_d;
  len_t                   len_q, len_d;
  logic                   last_q, last_d;
  len_t                   wcnt_q, wcnt_d;
  logic [C_REQ_IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [C_NUM_REQ-1:0]   arb_oh;
  logic [C_REQ_IDX_W-1:0] arb_idx;
  logic                   arb_any;

  len_t                   sel_len;
  logic                   sel_last;
  logic                   sel_valid;
  logic                   in_xfer;
  logic                   active;
  logic                   accept;
  logic [32:0]            wcnt_next;
  logic                   final_beat;

  rr_arbiter #(
    .NUM_REQ (C_NUM_REQ),
    .IDX_W   (C_REQ_IDX_W)
  ) u_rr_arbiter (
    .req         (REQ),
    .rr_ptr      (rr_ptr_q),
    .pick_onehot (arb_oh),
    .pick_idx    (arb_idx),
    .pick_valid  (arb_any)
  );

  assign sel_len    = REQ_LEN[int'(arb_idx)*32 +: 32];
  assign sel_last   = REQ_LAST[arb_idx];
  assign sel_valid  = REQ_DATA_VALID[idx_q];
  assign in_xfer    = (state_q == XFER);
  assign active     = (wcnt_q < len_q);
  assign accept     = in_xfer & active & sel_valid & CHNL_TX_DATA_REN;
  assign wcnt_next  = {1'b0, wcnt_q} + K_EXT;
  assign final_beat = (wcnt_next >= {1'b0, len_q});

  // State and datapath registers; reset abandons any transfer in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      gnt_oh_q <= '0;
      len_q    <= '0;
      last_q   <= 1'b0;
      wcnt_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      gnt_oh_q <= gnt_oh_d;
      len_q    <= len_d;
      last_q   <= last_d;
      wcnt_q   <= wcnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next-state logic: requests are only sampled in IDLE, so a grant always runs to completion.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    gnt_oh_d = gnt_oh_q;
    len_d    = len_q;
    last_d   = last_q;
    wcnt_d   = wcnt_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          idx_d    = arb_idx;
          gnt_oh_d = arb_oh;
          len_d    = sel_len;
          last_d   = sel_last;
          state_d  = OPEN;
        end
      end
      OPEN: begin
        if (CHNL_TX_ACK) begin
          state_d = (len_q == '0) ? DONE : XFER;
        end
      end
      XFER: begin
        if (accept) begin
          wcnt_d = wcnt_next[31:0];
          if (final_beat) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        rr_ptr_d = (idx_q == C_REQ_IDX_W'(C_NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
        wcnt_d   = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: grant and read-enable only ever reach the latched requester.
  always_comb begin
    CHNL_TX            = 1'b0;
    GNT                = '0;
    CHNL_TX_DATA_VALID = 1'b0;
    REQ_DATA_REN       = '0;
    REQ_DONE           = '0;
    case (state_q)
      OPEN: begin
        CHNL_TX = 1'b1;
        GNT     = gnt_oh_q;
      end
      XFER: begin
        CHNL_TX            = 1'b1;
        GNT                = gnt_oh_q;
        CHNL_TX_DATA_VALID = active & sel_valid;
        REQ_DATA_REN       = (active & CHNL_TX_DATA_REN) ? gnt_oh_q : '0;
      end
      DONE: begin
        REQ_DONE = gnt_oh_q;
      end
      default: begin
        CHNL_TX = 1'b0;
      end
    endcase
  end

  assign CHNL_TX_CLK  = CLK;
  assign CHNL_TX_LAST = last_q;
  assign CHNL_TX_LEN  = len_q;
  assign CHNL_TX_OFF  = '0;
  assign CHNL_TX_DATA = REQ_DATA[int'(idx_q)*C_PCI_DATA_WIDTH +: C_PCI_DATA_WIDTH];

endmodule
